// File: rtl/systolic_feeder.sv
// systolic_feeder: streams four operand vectors (A-row0, A-row1, B-col0, B-col1)
// from the operand buffer RAM into the edge ports of a 2x2 PE array.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   go, abort         start pulse (accepted only in IDLE), cancel running job
//   cfg_a_base/b_base base word addresses; row/col 1 sits at base+len
//   cfg_len           words per vector
//   busy, done        job active, one-cycle completion pulse
//   ram_ren/radr      RAM read strobe/address; ram_rdata returns one cycle later
//   a_in0..b_in1      edge data, awe0..bwe1 edge write enables
//   aff0..bff1        edge full flags (backpressure per lane)
module systolic_feeder #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 10,
  parameter int unsigned LW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          go,
  input  logic          abort,
  input  logic [AW-1:0] cfg_a_base,
  input  logic [AW-1:0] cfg_b_base,
  input  logic [LW-1:0] cfg_len,
  output logic          busy,
  output logic          done,
  output logic          ram_ren,
  output logic [AW-1:0] ram_radr,
  input  logic [DW-1:0] ram_rdata,
  output logic [DW-1:0] a_in0,
  output logic [DW-1:0] a_in1,
  output logic [DW-1:0] b_in0,
  output logic [DW-1:0] b_in1,
  output logic          awe0,
  output logic          awe1,
  output logic          bwe0,
  output logic          bwe1,
  input  logic          aff0,
  input  logic          aff1,
  input  logic          bff0,
  input  logic          bff1
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [AW-1:0]        a_base_q, b_base_q;
  logic [LW-1:0]        len_q;
  logic [3:0][LW-1:0]   idx_q;
  logic [3:0][DW-1:0]   skid_q;
  logic [3:0]           skid_v_q;
  logic [3:0]           infl_q;
  logic                 rd_pend_q;
  logic [1:0]           rd_lane_q;
  logic [1:0]           ptr_q;

  logic [3:0]           ff;
  logic [3:0]           we;
  logic [3:0]           elig;
  logic                 gnt;
  logic [1:0]           gnt_lane;
  logic [1:0]           cand;
  logic [AW-1:0]        lane_base [4];
  logic [AW-1:0]        len_ext;
  logic                 all_done;
  logic                 run_abort;

  // Lane order: 0=a0, 1=a1, 2=b0, 3=b1
  assign ff        = {bff1, bff0, aff1, aff0};
  assign we        = skid_v_q & ~ff;
  assign run_abort = (state_q == RUN) && abort;

  assign len_ext      = AW'(len_q);
  assign lane_base[0] = a_base_q;
  assign lane_base[1] = a_base_q + len_ext;
  assign lane_base[2] = b_base_q;
  assign lane_base[3] = b_base_q + len_ext;

  assign {bwe1, bwe0, awe1, awe0} = we;
  assign a_in0 = skid_q[0];
  assign a_in1 = skid_q[1];
  assign b_in0 = skid_q[2];
  assign b_in1 = skid_q[3];

  assign busy = (state_q == RUN);
  assign done = (state_q == FIN);

  // A lane may issue if its skid will be free by the time the read data returns.
  always_comb begin
    elig     = '0;
    all_done = (infl_q == '0) && (skid_v_q == '0);
    for (int l = 0; l < 4; l++) begin
      elig[l] = (state_q == RUN) && !abort && (idx_q[l] < len_q) && !infl_q[l] &&
                (!skid_v_q[l] || we[l]);
      if (idx_q[l] != len_q) all_done = 1'b0;
    end
  end

  // Round-robin: search begins one past the most recently granted lane.
  always_comb begin
    gnt      = 1'b0;
    gnt_lane = ptr_q;
    cand     = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!gnt && elig[cand]) begin
        gnt      = 1'b1;
        gnt_lane = cand;
      end
    end
  end

  assign ram_ren  = gnt;
  assign ram_radr = gnt ? (lane_base[gnt_lane] + AW'(idx_q[gnt_lane])) : '0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (go) state_d = (cfg_len == '0) ? FIN : RUN;
      RUN: begin
        if (abort)         state_d = IDLE;
        else if (all_done) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_base_q  <= '0;
      b_base_q  <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      skid_q    <= '0;
      skid_v_q  <= '0;
      infl_q    <= '0;
      rd_pend_q <= 1'b0;
      rd_lane_q <= '0;
      ptr_q     <= 2'd3;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && go) begin
        a_base_q <= cfg_a_base;
        b_base_q <= cfg_b_base;
        len_q    <= cfg_len;
        idx_q    <= '0;
      end
      for (int l = 0; l < 4; l++) begin
        if (we[l]) skid_v_q[l] <= 1'b0;
        if (rd_pend_q && rd_lane_q == 2'(l) && !run_abort) begin
          skid_q[l]   <= ram_rdata;
          skid_v_q[l] <= 1'b1;
          infl_q[l]   <= 1'b0;
        end
        if (gnt && gnt_lane == 2'(l)) begin
          infl_q[l] <= 1'b1;
          idx_q[l]  <= idx_q[l] + 1'b1;
        end
      end
      rd_pend_q <= gnt;
      rd_lane_q <= gnt_lane;
      if (gnt) ptr_q <= gnt_lane;
      // Abort drops buffered words and ignores the read that may still be returning.
      if (run_abort) begin
        skid_v_q  <= '0;
        infl_q    <= '0;
        rd_pend_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: table of directed jobs, hand-written
// corner sequences (len=0, abort, reset mid-job) and randomized jobs with random
// backpressure, all checked against per-lane expected word queues.
module tb_systolic_feeder;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst, go, abort;
  logic [AW-1:0] cfg_a_base, cfg_b_base;
  logic [LW-1:0] cfg_len;
  logic          busy, done, ram_ren;
  logic [AW-1:0] ram_radr;
  logic [DW-1:0] ram_rdata;
  logic [DW-1:0] a_in0, a_in1, b_in0, b_in1;
  logic          awe0, awe1, bwe0, bwe1;
  logic          aff0, aff1, bff0, bff1;

  systolic_feeder #(.DW(DW), .AW(AW), .LW(LW)) dut (
    .clk(clk), .rst(rst), .go(go), .abort(abort),
    .cfg_a_base(cfg_a_base), .cfg_b_base(cfg_b_base), .cfg_len(cfg_len),
    .busy(busy), .done(done), .ram_ren(ram_ren), .ram_radr(ram_radr),
    .ram_rdata(ram_rdata),
    .a_in0(a_in0), .a_in1(a_in1), .b_in0(b_in0), .b_in1(b_in1),
    .awe0(awe0), .awe1(awe1), .bwe0(bwe0), .bwe1(bwe1),
    .aff0(aff0), .aff1(aff1), .bff0(bff0), .bff1(bff1)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int reads = 0;
  int dones = 0;
  bit mon_on = 1'b0;
  bit first_seen;
  logic [DW-1:0] first_a0;
  logic [DW-1:0] salt = '0;
  logic [DW-1:0] exp_q [4][$];

  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    return DW'(a) ^ salt;
  endfunction

  // RAM model: data valid exactly one cycle after the strobe, junk otherwise.
  always @(posedge clk) ram_rdata <= ram_ren ? mem_f(ram_radr) : DW'($urandom);

  task automatic chk(input bit ok, input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted edge write must be the next expected word of its lane.
  always @(negedge clk) begin
    logic [3:0]          wev, ffv;
    logic [3:0][DW-1:0]  dv;
    logic [DW-1:0]       e;
    wev = {bwe1, bwe0, awe1, awe0};
    ffv = {bff1, bff0, aff1, aff0};
    dv  = {b_in1, b_in0, a_in1, a_in0};
    if (ram_ren) reads++;
    if (done) begin
      dones++;
      chk(!busy, "busy_low_at_done", 32'(busy), 0);
      if (mon_on) chk(exp_q[0].size() + exp_q[1].size() + exp_q[2].size() +
                      exp_q[3].size() == 0, "words_left_at_done",
                      32'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size() +
                          exp_q[3].size()), 0);
    end
    for (int l = 0; l < 4; l++) begin
      if (wev[l]) begin
        if (ffv[l]) chk(1'b0, $sformatf("we_while_full_lane%0d", l), 1, 0);
        if (mon_on) begin
          if (exp_q[l].size() == 0) begin
            chk(1'b0, $sformatf("extra_write_lane%0d", l), 32'(dv[l]), 0);
          end else begin
            e = exp_q[l].pop_front();
            chk(dv[l] == e, $sformatf("data_lane%0d", l), 32'(dv[l]), 32'(e));
          end
          if (l == 0 && !first_seen) begin
            first_seen = 1'b1;
            first_a0   = dv[0];
          end
        end
      end
    end
  end

  task automatic build_q(input logic [AW-1:0] ab, input logic [AW-1:0] bb,
                         input logic [LW-1:0] len);
    logic [AW-1:0] base [4];
    base[0] = ab;
    base[1] = ab + AW'(len);
    base[2] = bb;
    base[3] = bb + AW'(len);
    for (int l = 0; l < 4; l++) begin
      exp_q[l].delete();
      for (int k = 0; k < int'(len); k++) exp_q[l].push_back(mem_f(base[l] + AW'(k)));
    end
    first_seen = 1'b0;
  endtask

  task automatic run_job(input logic [AW-1:0] ab, input logic [AW-1:0] bb,
                         input logic [LW-1:0] len, input int st_start, input int st_len,
                         input int go2, input bit rnd_ff, input int exp_reads,
                         input logic [DW-1:0] exp_first, input string nm);
    int cyc;
    build_q(ab, bb, len);
    mon_on = 1'b1;
    reads  = 0;
    dones  = 0;
    cfg_a_base = ab;
    cfg_b_base = bb;
    cfg_len    = len;
    go = 1'b1;
    tick();
    go = 1'b0;
    chk(busy, {nm, "_busy_after_go"}, 32'(busy), 1);
    cyc = 0;
    while (dones == 0 && cyc < 3000) begin
      if (rnd_ff) begin
        {bff1, bff0, aff1, aff0} = 4'($urandom) & 4'($urandom);
      end else begin
        aff0 = (cyc >= st_start) && (cyc < st_start + st_len);
      end
      if (cyc == go2) begin
        go = 1'b1;
        cfg_a_base = ab + 10'h55;
        cfg_b_base = bb + 10'h21;
        cfg_len    = len + 8'd4;
      end else begin
        go = 1'b0;
      end
      tick();
      cyc++;
    end
    go = 1'b0;
    {bff1, bff0, aff1, aff0} = '0;
    chk(dones != 0, {nm, "_done_timeout"}, 32'(cyc), 3000);
    repeat (6) tick();
    chk(reads == exp_reads, {nm, "_read_count"}, 32'(reads), 32'(exp_reads));
    chk(dones == 1, {nm, "_done_pulses"}, 32'(dones), 1);
    chk(first_a0 == exp_first, {nm, "_first_a0"}, 32'(first_a0), 32'(exp_first));
    for (int l = 0; l < 4; l++)
      chk(exp_q[l].size() == 0, $sformatf("%s_missing_lane%0d", nm, l),
          32'(exp_q[l].size()), 0);
    mon_on = 1'b0;
  endtask

  typedef struct {
    logic [AW-1:0] ab;
    logic [AW-1:0] bb;
    logic [LW-1:0] len;
    int            st_start;
    int            st_len;
    int            go2;
    int            exp_reads;
    logic [DW-1:0] exp_first;
    string         nm;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int cyc;
    int d0;
    bit quiet;
    vecs[0] = '{10'h010, 10'h100, 8'd3,  -1, 0,  -1, 12, 16'h0010, "basic"};
    vecs[1] = '{10'h010, 10'h100, 8'd3,   3, 20, -1, 12, 16'h0010, "stall_a0"};
    vecs[2] = '{10'h010, 10'h100, 8'd3,  -1, 0,   2, 12, 16'h0010, "go_while_busy"};
    vecs[3] = '{10'h3FE, 10'h200, 8'd3,  -1, 0,  -1, 12, 16'h03FE, "wrap"};
    vecs[4] = '{10'h000, 10'h3F0, 8'd16, -1, 0,  -1, 64, 16'h0000, "len16"};

    rst = 1'b1; go = 1'b0; abort = 1'b0;
    cfg_a_base = '0; cfg_b_base = '0; cfg_len = '0;
    {bff1, bff0, aff1, aff0} = '0;
    repeat (3) tick();
    chk({busy, done, ram_ren, awe0, awe1, bwe0, bwe1} == '0, "reset_ctrl",
        32'({busy, done, ram_ren, awe0, awe1, bwe0, bwe1}), 0);
    chk({a_in0, a_in1, b_in0, b_in1, ram_radr} == '0, "reset_data", 32'(a_in0 | b_in1), 0);
    rst = 1'b0;
    tick();

    foreach (vecs[i])
      run_job(vecs[i].ab, vecs[i].bb, vecs[i].len, vecs[i].st_start, vecs[i].st_len,
              vecs[i].go2, 1'b0, vecs[i].exp_reads, vecs[i].exp_first, vecs[i].nm);

    // len=0: straight to FIN, no reads, busy never rises.
    reads = 0; dones = 0;
    cfg_len = '0; go = 1'b1;
    tick();
    go = 1'b0;
    chk(done, "len0_done", 32'(done), 1);
    chk(!busy, "len0_busy", 32'(busy), 0);
    tick();
    chk(!done, "len0_done_single", 32'(done), 0);
    repeat (4) tick();
    chk(reads == 0, "len0_no_reads", 32'(reads), 0);
    chk(dones == 1, "len0_done_count", 32'(dones), 1);

    // Abort after five reads.
    salt = 16'h5A00;
    build_q(10'h040, 10'h080, 8'd8);
    mon_on = 1'b1; reads = 0; dones = 0;
    cfg_a_base = 10'h040; cfg_b_base = 10'h080; cfg_len = 8'd8;
    go = 1'b1;
    tick();
    go = 1'b0;
    cyc = 0;
    while (reads < 5 && cyc < 100) begin tick(); cyc++; end
    chk(reads == 5, "abort_wait_reads", 32'(reads), 5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk(!busy, "abort_busy_low", 32'(busy), 0);
    mon_on = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (awe0 | awe1 | bwe0 | bwe1 | ram_ren | done) quiet = 1'b0;
    end
    chk(quiet, "abort_quiet", 32'(quiet), 1);
    chk(reads == 5 && dones == 0, "abort_no_more", 32'(reads), 5);
    tick();
    run_job(10'h123, 10'h321, 8'd2, -1, 0, -1, 1'b0, 8, mem_f(10'h123), "after_abort");

    // Reset in the middle of a job.
    build_q(10'h000, 10'h100, 8'd10);
    cfg_a_base = 10'h000; cfg_b_base = 10'h100; cfg_len = 8'd10;
    go = 1'b1;
    tick();
    go = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk({busy, done, ram_ren, awe0, awe1, bwe0, bwe1} == '0, "midrst_ctrl",
        32'({busy, done, ram_ren, awe0, awe1, bwe0, bwe1}), 0);
    chk({a_in0, a_in1, b_in0, b_in1} == '0, "midrst_data", 32'(a_in0 | a_in1 | b_in0), 0);
    d0 = dones;
    repeat (8) tick();
    chk(dones == d0 && !busy, "midrst_no_done", 32'(dones - d0), 0);

    // Randomized jobs with random backpressure on all lanes.
    for (int j = 0; j < 6; j++) begin
      logic [AW-1:0] ab, bb;
      logic [LW-1:0] ln;
      salt = DW'($urandom);
      ab = AW'($urandom);
      bb = AW'($urandom);
      ln = LW'($urandom_range(1, 20));
      run_job(ab, bb, ln, -1, 0, -1, 1'b1, 4 * int'(ln), mem_f(ab),
              $sformatf("rand%0d", j));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
